// File: rtl/cpu_debug_bus_slave_pkg.sv
// Shared types for the debug-bus bridge slave:
// FSM states, byte lane indices and the abort fill byte.
package cpu_debug_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_DONE,
      S_GAP
   } state_t;

   localparam logic [7:0] BYTE_FILL = 8'hFF;
   localparam int LANE_LO = 0;
   localparam int LANE_HI = 1;

endpackage

// File: rtl/cpu_debug_bus_slave_if.sv
// Bridge-side 16-bit port and CPU-side 8-bit debug bus,
// bundled so the slave, bridge and target each see one modport.
interface cpu_debug_bus_slave_if;

   logic [15:0] ext_address;
   logic        ext_bus_enable;
   logic [1:0]  ext_byte_enable;
   logic        ext_rw;
   logic [15:0] ext_write_data;
   logic [15:0] ext_read_data;
   logic        ext_acknowledge;
   logic        ext_irq;

   logic [15:0] bus_addr;
   logic        bus_req;
   logic        bus_we;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic        bus_ack;

   modport slave (
      input  ext_address, ext_bus_enable, ext_byte_enable,
      input  ext_rw, ext_write_data,
      output ext_read_data, ext_acknowledge, ext_irq,
      output bus_addr, bus_req, bus_we, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport master (
      output ext_address, ext_bus_enable, ext_byte_enable,
      output ext_rw, ext_write_data,
      input  ext_read_data, ext_acknowledge, ext_irq
   );

   modport target (
      input  bus_addr, bus_req, bus_we, bus_wdata,
      output bus_rdata, bus_ack
   );

endinterface

// File: rtl/cpu_debug_bus_slave_timeout_counter.sv
// Per-byte wait counter; expired flags the last allowed
// request cycle passing without an acknowledge.
module bus_timeout_counter #(
   parameter int LIMIT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic run,
   output logic expired
);

   localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (LIMIT != 0) && run && (cnt_q == LAST);

endmodule

// File: rtl/cpu_debug_bus_slave.sv
// Replays 16-bit bridge accesses as one or two byte cycles on the
// 8-bit CPU debug bus, with per-byte timeout and sticky error irq.
module cpu_debug_bus_slave
   import cpu_debug_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        error_clear,
   cpu_debug_bus_slave_if.slave        dbg
);

   state_t      state_q, state_d;
   logic [14:0] addr_q, addr_d;
   logic        rw_q, rw_d;
   logic [1:0]  be_q, be_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        abort_q, abort_d;
   logic        req_q, req_d;
   logic [15:0] baddr_q, baddr_d;
   logic        we_q, we_d;
   logic [7:0]  bwd_q, bwd_d;
   logic        ack_q, ack_d;
   logic [15:0] xrd_q, xrd_d;
   logic        err_q, err_d;
   logic        byte_start;
   logic        timeout;
   logic        expired;

   bus_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_tmo (
      .clock   (clock),
      .reset   (reset),
      .start   (byte_start),
      .run     (req_q && !dbg.bus_ack),
      .expired (expired)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      abort_d    = abort_q;
      req_d      = req_q;
      baddr_d    = baddr_q;
      we_d       = we_q;
      bwd_d      = bwd_q;
      ack_d      = 1'b0;
      xrd_d      = xrd_q;
      byte_start = 1'b0;
      timeout    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (dbg.ext_bus_enable) begin
               addr_d  = dbg.ext_address[15:1];
               rw_d    = dbg.ext_rw;
               be_d    = dbg.ext_byte_enable;
               wdata_d = dbg.ext_write_data;
               rdata_d = '0;
               abort_d = 1'b0;
               we_d    = !dbg.ext_rw;
               if (dbg.ext_byte_enable[LANE_LO]) begin
                  state_d    = S_LO;
                  req_d      = 1'b1;
                  byte_start = 1'b1;
                  baddr_d    = {dbg.ext_address[15:1], 1'b0};
                  bwd_d      = dbg.ext_write_data[8*LANE_LO +: 8];
               end else if (dbg.ext_byte_enable[LANE_HI]) begin
                  state_d    = S_HI;
                  req_d      = 1'b1;
                  byte_start = 1'b1;
                  baddr_d    = {dbg.ext_address[15:1], 1'b1};
                  bwd_d      = dbg.ext_write_data[8*LANE_HI +: 8];
               end else begin
                  state_d = S_DONE;
                  ack_d   = 1'b1;
                  xrd_d   = '0;
               end
            end
         end
         S_LO: begin
            if (abort_q) begin
               state_d = S_DONE;
               abort_d = 1'b0;
               ack_d   = 1'b1;
               xrd_d   = rdata_q;
            end else if (dbg.bus_ack) begin
               if (rw_q) rdata_d[8*LANE_LO +: 8] = dbg.bus_rdata;
               if (be_q[LANE_HI]) begin
                  state_d    = S_HI;
                  byte_start = 1'b1;
                  baddr_d    = {addr_q, 1'b1};
                  bwd_d      = wdata_q[8*LANE_HI +: 8];
               end else begin
                  state_d = S_DONE;
                  req_d   = 1'b0;
                  ack_d   = 1'b1;
                  xrd_d   = rdata_d;
               end
            end else if (expired) begin
               // req drops now; the stall cycle lets the target see it before ack
               timeout = 1'b1;
               req_d   = 1'b0;
               abort_d = 1'b1;
               rdata_d[8*LANE_LO +: 8] = BYTE_FILL;
               if (be_q[LANE_HI]) rdata_d[8*LANE_HI +: 8] = BYTE_FILL;
            end
         end
         S_HI: begin
            if (abort_q) begin
               state_d = S_DONE;
               abort_d = 1'b0;
               ack_d   = 1'b1;
               xrd_d   = rdata_q;
            end else if (dbg.bus_ack) begin
               if (rw_q) rdata_d[8*LANE_HI +: 8] = dbg.bus_rdata;
               state_d = S_DONE;
               req_d   = 1'b0;
               ack_d   = 1'b1;
               xrd_d   = rdata_d;
            end else if (expired) begin
               timeout = 1'b1;
               req_d   = 1'b0;
               abort_d = 1'b1;
               rdata_d[8*LANE_HI +: 8] = BYTE_FILL;
            end
         end
         S_DONE: state_d = S_GAP;
         S_GAP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      err_d = timeout ? 1'b1 : (error_clear ? 1'b0 : err_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         abort_q <= 1'b0;
         req_q   <= 1'b0;
         baddr_q <= '0;
         we_q    <= 1'b0;
         bwd_q   <= '0;
         ack_q   <= 1'b0;
         xrd_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         abort_q <= abort_d;
         req_q   <= req_d;
         baddr_q <= baddr_d;
         we_q    <= we_d;
         bwd_q   <= bwd_d;
         ack_q   <= ack_d;
         xrd_q   <= xrd_d;
         err_q   <= err_d;
      end
   end

   assign dbg.bus_req         = req_q;
   assign dbg.bus_addr        = baddr_q;
   assign dbg.bus_we          = we_q;
   assign dbg.bus_wdata       = bwd_q;
   assign dbg.ext_acknowledge = ack_q;
   assign dbg.ext_read_data   = xrd_q;
   assign dbg.ext_irq         = err_q;

endmodule

// File: doc/cpu_debug_bus_slave.md
# cpu_debug_bus_slave

Terminates one external-bus-bridge port of the debug subsystem (16-bit address, 16-bit data, byte enables, acknowledge/irq) and replays each access as one or two byte cycles on the 8-bit NES CPU debug bus. It sits directly downstream of the debug subsystem's external interface, with the CPU-side debug bus as its target. It also adds a per-byte timeout and a sticky error that drives the bridge irq.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles a byte request may wait for `bus_ack`; 0 disables the timeout.
- `clock` in 1: single clock for everything.
- `reset` in 1: synchronous, active-high.
- `ext_address` in 16: byte address from the bridge; bit 0 ignored (halfword-aligned).
- `ext_bus_enable` in 1: access request, held by the bridge until `ext_acknowledge`.
- `ext_byte_enable` in 2: bit0 = low lane, bit1 = high lane.
- `ext_rw` in 1: 1 = read, 0 = write.
- `ext_write_data` in 16: write data; lane i = bits [8i+7:8i].
- `ext_read_data` out 16: read data, valid while `ext_acknowledge`=1.
- `ext_acknowledge` out 1: one-cycle completion pulse.
- `ext_irq` out 1: equals the sticky error flag.
- `bus_addr` out 16: CPU-bus byte address.
- `bus_req` out 1: byte request.
- `bus_we` out 1: 1 = write.
- `bus_wdata` out 8: byte write data.
- `bus_rdata` in 8: byte read data, sampled on handshake.
- `bus_ack` in 1: target completes the byte.
- `error_clear` in 1: clears the sticky error.

## Operation
- States: IDLE, LO, HI, DONE, GAP.
- **IDLE** with `ext_bus_enable`=1: latch address, rw, byte enables and write data.
  - Lane bit0 set → LO.
  - Else bit1 set → HI.
  - Else (enables = 00) → DONE, with no bus cycle and read data 0x0000.
- **LO**: drive `bus_addr`={addr[15:1],0}, `bus_we`=!rw, `bus_wdata`=wdata[7:0], `bus_req`=1.
  - On `bus_req`&&`bus_ack`: reads capture `bus_rdata` into lane 0.
  - Then → HI if bit1 set, else → DONE.
- **HI**: same as LO, but address {addr[15:1],1}, lane 1, then → DONE.
- **DONE**: `ext_acknowledge`=1 for exactly one cycle; `ext_read_data` = captured lanes; disabled lanes read 0x00. → GAP.
- **GAP**: ignore `ext_bus_enable` for one cycle, because the bridge drops it the cycle after acknowledge. → IDLE.
- **Bus handshake**: `bus_addr`/`bus_we`/`bus_wdata` stay stable while `bus_req`=1. `bus_ack` is don't-care when `bus_req`=0. A zero-wait target may raise `bus_ack` in the first `bus_req` cycle.
- **Timeout** (`TIMEOUT_CYCLES`>0):
  - The counter restarts at each byte request.
  - If `TIMEOUT_CYCLES` request cycles pass without `bus_ack`, drop `bus_req`, set the error flag and abort the remaining lanes.
  - Every enabled lane not completed reads 0xFF. → DONE; the access is still acknowledged.
- **Error flag**: set by a timeout, cleared by `error_clear`. If set and clear happen in the same cycle, set wins.
- **Reset** (also mid-transaction): state → IDLE. `bus_req`, `ext_acknowledge`, `ext_irq` = 0; `ext_read_data`, `bus_addr`, `bus_wdata` = 0; `bus_we` = 0; counter = 0. No acknowledge is issued for the aborted access.

## Timing
- Cycle 0 = IDLE sees `ext_bus_enable`.
- `bus_req` asserts in cycle 1, registered from state.
- Acknowledge cycle with a zero-wait target:
  - enables 00 → cycle 1.
  - one lane → cycle 2.
  - both lanes → cycle 3.
- Each target wait cycle adds one cycle.
- The earliest next access is accepted 2 cycles after acknowledge (DONE, GAP, then IDLE).
- Timeout on a single lane: `bus_req` high for `TIMEOUT_CYCLES` cycles, low the next cycle, acknowledge the cycle after.
- `ext_irq` rises the cycle after the timeout decision. It falls the cycle after `error_clear`.
- All outputs are registered; no combinational path from `ext_*` inputs to `bus_*` outputs.

## Structure
- Package `cpu_debug_bus_pkg` holds:
  - the state enum (IDLE, LO, HI, DONE, GAP),
  - `BYTE_FILL` = 8'hFF,
  - lane index constants.
- Sub-module `bus_timeout_counter`:
  - Parameter `LIMIT`, width $clog2(LIMIT+1).
  - Ports: `clock`, `reset`, `start`, `run`, `expired`.
  - `expired` is tied 0 when `LIMIT`=0.
- FSM, lane capture and error flag live in the top module.

## Test plan
- Read, enables=11, addr 0x2002, target returns 0x34 then 0x12 with zero wait:
  - bus addresses 0x2002 then 0x2003,
  - `ext_read_data`=0x1234,
  - acknowledge in cycle 3.
- Write, enables=10, addr 0x0100, data 0xAB00, target waits 2 cycles:
  - single byte write of 0xAB at 0x0101,
  - acknowledge in cycle 4.
- Enables=00 read:
  - no `bus_req`,
  - acknowledge in cycle 1 with 0x0000.
- `TIMEOUT_CYCLES`=4, enables=11, target never acks:
  - `bus_req` for 4 cycles at 0x2002 only,
  - `ext_read_data`=0xFFFF with acknowledge,
  - `ext_irq`=1 until `error_clear`.
- Second timeout coinciding with `error_clear` → `ext_irq` stays 1.
- Reset asserted in HI state → `bus_req`=0 next cycle, no acknowledge, and the next access completes normally.
